// File: rtl/four_to_eight_pkg.sv
// Shared types and defaults for the four_to_eight nibble packer.
package four_to_eight_pkg;

    localparam int IN_W_DEFAULT = 4;

    typedef enum logic {
        WAIT_H = 1'b0,
        WAIT_L = 1'b1
    } state_t;

endpackage

// File: rtl/four_to_eight.sv
// Serial-to-parallel packer: pairs of IN_W-bit nibbles become one 2*IN_W word.
// Define FOUR_TO_EIGHT_LSB_FIRST_EN to treat the first nibble as the low half.
module four_to_eight
    import four_to_eight_pkg::*;
#(
    parameter int IN_W = IN_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DATA_VALID,
    input  logic [IN_W-1:0]   DATA_IN,
    output logic              OUTPUT_VALID,
    output logic              EN_H,
    output logic              EN_L,
    output logic [2*IN_W-1:0] DATA_OUT
);

    state_t          state;
    state_t          state_next;
    logic [IN_W-1:0] first_q;
    logic            take_first;
    logic            take_second;

    // Gating with RESET keeps both enables low while reset is held,
    // even if DATA_VALID is already asserted.
    assign take_first  = RESET & DATA_VALID & (state == WAIT_H);
    assign take_second = RESET & DATA_VALID & (state == WAIT_L);

`ifdef FOUR_TO_EIGHT_LSB_FIRST_EN
    assign EN_L = take_first;
    assign EN_H = take_second;
`else
    assign EN_H = take_first;
    assign EN_L = take_second;
`endif

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        if (take_first) begin
            state_next = WAIT_L;
        end else if (take_second) begin
            state_next = WAIT_H;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= WAIT_H;
        end else begin
            state <= state_next;
        end
    end

    // The first nibble is parked here until its partner arrives, so DATA_OUT
    // never exposes a half-built word.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            first_q <= '0;
        end else if (take_first) begin
            first_q <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DATA_OUT     <= '0;
            OUTPUT_VALID <= 1'b0;
        end else begin
            OUTPUT_VALID <= take_second;
            if (take_second) begin
`ifdef FOUR_TO_EIGHT_LSB_FIRST_EN
                DATA_OUT <= {DATA_IN, first_q};
`else
                DATA_OUT <= {first_q, DATA_IN};
`endif
            end
        end
    end

endmodule

// File: tb/tb_four_to_eight.sv
// Directed self-checking bench for four_to_eight (default or LSB-first build).
module tb_four_to_eight;

    logic       CLK;
    logic       RESET;
    logic       DATA_VALID;
    logic [3:0] DATA_IN;
    logic       OUTPUT_VALID;
    logic       EN_H;
    logic       EN_L;
    logic [7:0] DATA_OUT;

    int checks;
    int errors;

    four_to_eight #(.IN_W(4)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DATA_VALID   (DATA_VALID),
        .DATA_IN      (DATA_IN),
        .OUTPUT_VALID (OUTPUT_VALID),
        .EN_H         (EN_H),
        .EN_L         (EN_L),
        .DATA_OUT     (DATA_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Enable that qualifies the first / second nibble of a word in this build.
    logic en_first;
    logic en_second;
`ifdef FOUR_TO_EIGHT_LSB_FIRST_EN
    assign en_first  = EN_L;
    assign en_second = EN_H;
`else
    assign en_first  = EN_H;
    assign en_second = EN_L;
`endif

    function automatic logic [7:0] word_of(input logic [3:0] first, input logic [3:0] second);
`ifdef FOUR_TO_EIGHT_LSB_FIRST_EN
        return {second, first};
`else
        return {first, second};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d);
        DATA_VALID = v;
        DATA_IN    = d;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        RESET      = 1'b0;
        DATA_VALID = 1'b0;
        DATA_IN    = 4'h0;

        // Reset: enables stay low even with DATA_VALID asserted.
        repeat (2) tick();
        drive(1'b1, 4'h9);
        check("rst_en_h", EN_H, 1'b0);
        check("rst_en_l", EN_L, 1'b0);
        check("rst_data", DATA_OUT, 8'h00);
        check("rst_ov", OUTPUT_VALID, 1'b0);
        drive(1'b0, 4'h0);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_data", DATA_OUT, 8'h00);
            check("idle_ov", OUTPUT_VALID, 1'b0);
            check("idle_en_h", EN_H, 1'b0);
            check("idle_en_l", EN_L, 1'b0);
        end

        // Basic pair F,5.
        drive(1'b1, 4'hF);
        check("pair_en_first", en_first, 1'b1);
        check("pair_en_second_lo", en_second, 1'b0);
        tick();
        check("pair_half_ov", OUTPUT_VALID, 1'b0);
        check("pair_half_data", DATA_OUT, 8'h00);
        drive(1'b1, 4'h5);
        check("pair_en_second", en_second, 1'b1);
        check("pair_en_first_lo", en_first, 1'b0);
        tick();
        check("pair_data", DATA_OUT, word_of(4'hF, 4'h5));
        check("pair_ov", OUTPUT_VALID, 1'b1);
        drive(1'b0, 4'h0);
        tick();
        check("pair_ov_drop", OUTPUT_VALID, 1'b0);
        tick();
        check("pair_hold", DATA_OUT, word_of(4'hF, 4'h5));

        // Gap between high and low nibble.
        drive(1'b1, 4'hA);
        tick();
        drive(1'b0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gap_ov", OUTPUT_VALID, 1'b0);
            check("gap_hold", DATA_OUT, word_of(4'hF, 4'h5));
            check("gap_en_h", EN_H, 1'b0);
        end
        drive(1'b1, 4'h3);
        check("gap_en_second", en_second, 1'b1);
        tick();
        check("gap_data", DATA_OUT, word_of(4'hA, 4'h3));
        check("gap_ov_hit", OUTPUT_VALID, 1'b1);
        drive(1'b0, 4'h0);
        tick();
        check("gap_ov_drop", OUTPUT_VALID, 1'b0);

        // Back-to-back 1,2,3,4.
        drive(1'b1, 4'h1);
        check("b2b_en1", en_first, 1'b1);
        tick();
        check("b2b_ov1", OUTPUT_VALID, 1'b0);
        drive(1'b1, 4'h2);
        check("b2b_en2", en_second, 1'b1);
        tick();
        check("b2b_word1", DATA_OUT, word_of(4'h1, 4'h2));
        check("b2b_ov2", OUTPUT_VALID, 1'b1);
        drive(1'b1, 4'h3);
        check("b2b_en3", en_first, 1'b1);
        check("b2b_en3_other", en_second, 1'b0);
        tick();
        check("b2b_ov3", OUTPUT_VALID, 1'b0);
        check("b2b_hold", DATA_OUT, word_of(4'h1, 4'h2));
        drive(1'b1, 4'h4);
        check("b2b_en4", en_second, 1'b1);
        tick();
        check("b2b_word2", DATA_OUT, word_of(4'h3, 4'h4));
        check("b2b_ov4", OUTPUT_VALID, 1'b1);
        drive(1'b0, 4'h0);
        tick();
        check("b2b_ov_drop", OUTPUT_VALID, 1'b0);

        // Reset mid-word discards the pending nibble.
        drive(1'b1, 4'hC);
        tick();
        drive(1'b0, 4'h0);
        check("mid_waiting", en_second, 1'b0);
        #1;
        RESET = 1'b0;
        #1;
        check("mid_rst_data", DATA_OUT, 8'h00);
        check("mid_rst_ov", OUTPUT_VALID, 1'b0);
        RESET = 1'b1;
        drive(1'b1, 4'h7);
        check("mid_en_first", en_first, 1'b1);
        tick();
        check("mid_ov_lo", OUTPUT_VALID, 1'b0);
        drive(1'b1, 4'h8);
        tick();
        check("mid_data", DATA_OUT, word_of(4'h7, 4'h8));
        check("mid_ov", OUTPUT_VALID, 1'b1);
        drive(1'b0, 4'h0);
        tick();
        check("mid_ov_drop", OUTPUT_VALID, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_to_eight.md
Name: four_to_eight

Overview:
- Serial-to-parallel nibble packer. Accepts 4-bit nibbles qualified by DATA_VALID and assembles each consecutive pair into one 8-bit word.
- The first accepted nibble forms the high half and the second forms the low half.
- Sits between a narrow nibble source and byte-wide downstream logic. Presents the word with a one-cycle OUTPUT_VALID strobe and holds DATA_OUT until the next word completes.

Parameters:
- IN_W, default 4, input nibble width. The output width is always 2*IN_W.

Ports:
- CLK  in  1  single system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- DATA_VALID  in  1  qualifies DATA_IN in the current cycle.
- DATA_IN  in  IN_W  nibble data.
- OUTPUT_VALID  out  1  one-cycle strobe; DATA_OUT holds a newly completed word.
- EN_H  out  1  high-half register load enable (combinational status).
- EN_L  out  1  low-half register load enable (combinational status).
- DATA_OUT  out  2*IN_W  assembled word {high, low}.

Interface rule: one clock; reset is asynchronous and active-low (ports named CLK and RESET).

Behaviour:
- FSM states:
  - WAIT_H: expecting the high nibble.
  - WAIT_L: expecting the low nibble.
- Reset (RESET=0, asynchronous assertion):
  - state=WAIT_H, high register=0, DATA_OUT=0, OUTPUT_VALID=0.
  - EN_H/EN_L evaluate to 0 while in reset.
- Accepting the high nibble:
  - EN_H = DATA_VALID & (state==WAIT_H).
  - On an edge with EN_H: high register <= DATA_IN; state -> WAIT_L.
- Accepting the low nibble:
  - EN_L = DATA_VALID & (state==WAIT_L).
  - On an edge with EN_L: DATA_OUT <= {high register, DATA_IN}; OUTPUT_VALID <= 1; state -> WAIT_H.
- Latency: DATA_OUT and OUTPUT_VALID are valid immediately after the edge that accepts the low nibble (0 extra cycles).
- OUTPUT_VALID is high for exactly one cycle per completed word; otherwise 0.
- DATA_OUT holds its last completed word indefinitely. It never shows a half-built word.
- DATA_VALID=0: no state change. Gaps of any length are allowed between the high and low nibbles, and between words.
- Back-to-back: with DATA_VALID held high, nibbles are accepted every cycle and words complete every second cycle. The OUTPUT_VALID of one word coincides with the acceptance of the next high nibble.
- No abort or timeout: a lone high nibble waits in WAIT_L until a low nibble arrives or reset is applied.
- Reset mid-word (in WAIT_L) discards the pending high nibble and clears DATA_OUT.
- Exactly one of EN_H/EN_L can be high at a time.

Optional Feature:
- Macro: FOUR_TO_EIGHT_LSB_FIRST_EN.
- Defined: the first accepted nibble is the low half and the second is the high half. DATA_OUT <= {DATA_IN, first}.
  - EN_H then qualifies the second nibble and EN_L the first (state names are unchanged in meaning of order).
- Undefined: MSB-first order as described above.
- Handshake, latency and reset behaviour are identical in both builds.

Decomposition:
- Package four_to_eight_pkg holds:
  - IN_W_DEFAULT=4.
  - state enum typedef (WAIT_H, WAIT_L), 1-bit encoding.
- No sub-module needed. The FSM, the half register and the output register live in one module.

Test Plan:
- Reset: hold RESET=0, then release with DATA_VALID=0 for 3 cycles -> DATA_OUT=8'h00, OUTPUT_VALID=0, EN_H=EN_L=0.
- Basic pair: DATA_IN=4'hF with DATA_VALID=1 for one edge, then 4'h5 for one edge, then DATA_VALID=0 -> DATA_OUT=8'hF5, OUTPUT_VALID=1 for exactly one cycle. DATA_OUT remains 8'hF5 two cycles later.
- Gap: 4'hA, then DATA_VALID=0 for 5 cycles, then 4'h3 -> no strobe during the gap, DATA_OUT holds the old word; then DATA_OUT=8'hA3 with one strobe.
- Back-to-back: DATA_VALID=1 continuously with 1,2,3,4 -> strobes two cycles apart with 8'h12 then 8'h34. EN_H/EN_L alternate every cycle.
- Reset mid-word: 4'hC accepted, RESET pulsed low between edges, then 4'h7, 4'h8 -> DATA_OUT=8'h78 (the pending C is discarded). DATA_OUT=0 immediately on reset assertion.
- LSB-first build: with FOUR_TO_EIGHT_LSB_FIRST_EN, sequence F,5 -> DATA_OUT=8'h5F.
